alu_logic_shift_seq: RTL and testbench
======================================

ALU_LOGIC_SHIFT_SEQ -- requirements
Module: alu_logic_shift_seq

Interface
REQ-001 SHALL provide: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL provide: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL provide: in_valid  input  1  upstream request valid.
REQ-004 SHALL provide: in_ready  output  1  block can accept a request.
REQ-005 SHALL provide: op  input  3  operation code: 000 AND, 001 OR, 010 XOR, 011 NOT a, 100 LSL, 101 LSR, 110 ASR, 111 reserved.
REQ-006 SHALL provide: a  input  16  operand A, shifted value for shifts.
REQ-007 SHALL provide: b  input  16  operand B; unsigned shift amount for shifts.
REQ-008 SHALL provide: out_valid  output  1  result valid.
REQ-009 SHALL provide: out_ready  input  1  downstream accepts result.
REQ-010 SHALL provide: result  output  16  operation result.
REQ-011 SHALL provide: zero  output  1  result == 16'h0000.
REQ-012 SHALL provide: err  output  1  illegal/disabled opcode flag, qualified by out_valid.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 SHALL accept a request on a rising edge with in_valid && in_ready, latching op, a, b; inputs are otherwise ignored.
REQ-015 Logic ops (AND/OR/XOR/NOT) SHALL compute bitwise on acceptance and go IDLE->DONE; out_valid high the cycle after acceptance.
REQ-016 Shift ops SHALL load working register with a and counter n = min(b,16); n = 0 goes IDLE->DONE with result = a.
REQ-017 For n > 0, SHALL go IDLE->SHIFT; each SHIFT cycle shifts one bit and decrements n; the edge with n = 1 goes SHIFT->DONE.
REQ-018 Shift latency SHALL be exactly 1+n cycles from acceptance to out_valid; one bit per cycle, no multi-bit steps.
REQ-019 LSL SHALL insert 0 at bit 0; LSR SHALL insert 0 at bit 15; ASR SHALL replicate bit 15.
REQ-020 b >= 16 SHALL clamp to 16: LSL/LSR yield 0, ASR yields 16 copies of a[15].
REQ-021 Opcode 111 (and 110 when disabled) SHALL go IDLE->DONE with result 0, zero 1, err 1.
REQ-022 In DONE, result/zero/err SHALL hold stable until out_valid && out_ready; that edge returns to IDLE.
REQ-023 SHALL NOT accept a new request in the same cycle a result is consumed (in_ready low in DONE); back-to-back throughput one op per (latency+1) cycles minimum.
REQ-024 zero and err SHALL be registered alongside result, never combinational from inputs.
REQ-025 out_ready in IDLE/SHIFT and in_valid outside IDLE SHALL have no effect.

Reset
REQ-026 rst high at a rising edge SHALL force IDLE, in_ready 1, out_valid 0, result 0, zero 0, err 0, counter 0.
REQ-027 Reset SHALL take priority over any handshake in the same cycle; an in-flight shift or unconsumed result is discarded.

Configuration
REQ-028 Macro ALU_LOGIC_SHIFT_SEQ_ASR_EN defined: opcode 110 performs ASR per REQ-016..020.
REQ-029 Macro undefined: ASR logic compiled out; opcode 110 treated as illegal per REQ-021; port list unchanged.

Verification
REQ-030 AND a=16'hF0F0 b=16'h0FF0, out_ready=1 -> out_valid 1 cycle after accept, result 16'h00F0, zero 0, err 0.
REQ-031 LSL a=16'h0001 b=3 -> out_valid 4 cycles after accept, result 16'h0008; LSR a=16'h8000 b=15 -> 16'h0001 after 16 cycles.
REQ-032 LSR a=16'hFFFF b=16'h0100 -> clamped, 17 cycles, result 16'h0000, zero 1; with ASR_EN, ASR a=16'h8000 b=20 -> 16'hFFFF.
REQ-033 Opcode 111 (and 110 without ASR_EN) a=16'h1234 -> 1 cycle, result 0, zero 1, err 1.
REQ-034 XOR result held 5 cycles with out_ready 0 -> result stable, in_ready 0, in_valid pulses ignored; release -> IDLE next edge.
REQ-035 rst asserted mid-LSL (b=10, cycle 4) -> next edge IDLE, out_valid 0, result 0; fresh NOT a=16'h00FF -> 16'hFF00.

Source files
------------

// File: rtl/alu_logic_shift_seq.sv
// Sequential 16-bit logic/shift unit. Shifts advance one bit per cycle; ready/valid on both sides.
// Define ALU_LOGIC_SHIFT_SEQ_ASR_EN to enable opcode 110 (ASR); otherwise 110 is flagged illegal.
module alu_logic_shift_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        zero,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nx;
  logic [2:0]  op_q, op_nx;
  logic [15:0] work, work_nx;
  logic [4:0]  cnt, cnt_nx;
  logic        zero_q, zero_nx;
  logic        err_q, err_nx;

  logic [15:0] logic_res;
  logic [15:0] shifted;
  logic [4:0]  amt;
  logic        is_logic;
  logic        is_shift;

  // Shift amounts of 16 and above all saturate to a full 16-step shift.
  assign amt      = (|b[15:4]) ? 5'd16 : {1'b0, b[3:0]};
  assign is_logic = ~op[2];

  always_comb begin
    is_shift = (op == 3'b100) || (op == 3'b101);
`ifdef ALU_LOGIC_SHIFT_SEQ_ASR_EN
    if (op == 3'b110) is_shift = 1'b1;
`endif
  end

  always_comb begin
    case (op[1:0])
      2'b00:   logic_res = a & b;
      2'b01:   logic_res = a | b;
      2'b10:   logic_res = a ^ b;
      default: logic_res = ~a;
    endcase
  end

  always_comb begin
    case (op_q)
      3'b100:  shifted = {work[14:0], 1'b0};
      3'b101:  shifted = {1'b0, work[15:1]};
`ifdef ALU_LOGIC_SHIFT_SEQ_ASR_EN
      3'b110:  shifted = {work[15], work[15:1]};
`endif
      default: shifted = work;
    endcase
  end

  always_comb begin
    state_nx = state;
    op_nx    = op_q;
    work_nx  = work;
    cnt_nx   = cnt;
    zero_nx  = zero_q;
    err_nx   = err_q;
    case (state)
      IDLE: begin
        if (in_valid) begin
          op_nx  = op;
          err_nx = 1'b0;
          if (is_logic) begin
            work_nx  = logic_res;
            zero_nx  = (logic_res == 16'h0000);
            state_nx = DONE;
          end else if (is_shift) begin
            work_nx = a;
            cnt_nx  = amt;
            if (amt == 5'd0) begin
              zero_nx  = (a == 16'h0000);
              state_nx = DONE;
            end else begin
              state_nx = SHIFT;
            end
          end else begin
            work_nx  = '0;
            zero_nx  = 1'b1;
            err_nx   = 1'b1;
            state_nx = DONE;
          end
        end
      end
      SHIFT: begin
        work_nx = shifted;
        cnt_nx  = cnt - 5'd1;
        if (cnt == 5'd1) begin
          zero_nx  = (shifted == 16'h0000);
          state_nx = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      work   <= '0;
      cnt    <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      op_q   <= op_nx;
      work   <= work_nx;
      cnt    <= cnt_nx;
      zero_q <= zero_nx;
      err_q  <= err_nx;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = work;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_logic_shift_seq.sv
// Scoreboard bench for alu_logic_shift_seq; expectations come from a behavioural model.
module tb_alu_logic_shift_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero;
  logic        err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        e;
    int unsigned lat;
  } exp_t;

  exp_t sb[$];

  alu_logic_shift_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    exp_t r;
    int unsigned n;
    logic shift_op;
    logic illegal;
    n = (y > 16'd16) ? 16 : int'(y);
    shift_op = 1'b0;
    illegal  = 1'b0;
    r.res = '0;
    case (o)
      3'b000: r.res = x & y;
      3'b001: r.res = x | y;
      3'b010: r.res = x ^ y;
      3'b011: r.res = ~x;
      3'b100: begin shift_op = 1'b1; r.res = (n >= 16) ? 16'h0000 : (x << n); end
      3'b101: begin shift_op = 1'b1; r.res = (n >= 16) ? 16'h0000 : (x >> n); end
`ifdef ALU_LOGIC_SHIFT_SEQ_ASR_EN
      3'b110: begin shift_op = 1'b1; r.res = (n >= 16) ? {16{x[15]}} : 16'($signed(x) >>> n); end
`endif
      default: illegal = 1'b1;
    endcase
    r.z   = (r.res == 16'h0000);
    r.e   = illegal;
    r.lat = shift_op ? 1 + n : 1;
    return r;
  endfunction

  task automatic run_op(input string name, input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    exp_t ex;
    int unsigned lat;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s in_ready: got %b want 1", name, in_ready);
    end
    in_valid = 1'b1; op = o; a = x; b = y;
    sb.push_back(model(o, x, y));
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (out_valid !== 1'b1 && lat < 40);
    ex = sb.pop_front();
    n_cmp++;
    if (lat !== ex.lat) begin
      n_bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, ex.lat);
    end
    n_cmp++;
    if (result !== ex.res || zero !== ex.z || err !== ex.e) begin
      n_bad++;
      $display("FAIL %s result: got %h z%b e%b want %h z%b e%b", name, result, zero, err, ex.res, ex.z, ex.e);
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL %s release: got rdy%b vld%b want rdy1 vld0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0000 || zero !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: got rdy%b vld%b %h z%b e%b want rdy1 vld0 0000 z0 e0", in_ready, out_valid, result, zero, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_logic();
    run_op("and", 3'b000, 16'hF0F0, 16'h0FF0);
    run_op("or",  3'b001, 16'hF000, 16'h000F);
    run_op("xor", 3'b010, 16'hA5A5, 16'h5A5A);
    run_op("xor_zero", 3'b010, 16'h1234, 16'h1234);
    run_op("not", 3'b011, 16'h00FF, 16'h1111);
  endtask

  task automatic test_shift();
    run_op("lsl3", 3'b100, 16'h0001, 16'd3);
    run_op("lsr15", 3'b101, 16'h8000, 16'd15);
    run_op("lsr_clamp", 3'b101, 16'hFFFF, 16'h0100);
    run_op("lsl0", 3'b100, 16'hBEEF, 16'd0);
    run_op("lsl16", 3'b100, 16'hFFFF, 16'd16);
    run_op("asr20", 3'b110, 16'h8000, 16'd20);
    run_op("asr4", 3'b110, 16'h8100, 16'd4);
    run_op("asr_pos", 3'b110, 16'h4000, 16'd3);
    for (int i = 0; i < 6; i++)
      run_op("rand_shift", 3'($urandom_range(4, 6)), 16'($urandom), 16'($urandom_range(0, 20)));
  endtask

  task automatic test_illegal();
    run_op("op111", 3'b111, 16'h1234, 16'h0003);
  endtask

  task automatic test_hold();
    exp_t ex;
    int unsigned lat;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; op = 3'b010; a = 16'h00FF; b = 16'h0F0F;
    sb.push_back(model(3'b010, 16'h00FF, 16'h0F0F));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (out_valid !== 1'b1 && lat < 40);
    ex = sb.pop_front();
    n_cmp++;
    if (lat !== ex.lat || result !== ex.res) begin
      n_bad++; $display("FAIL hold_first: got lat%0d %h want lat%0d %h", lat, result, ex.lat, ex.res);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = 3'b011; a = 16'($urandom); b = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== ex.res || zero !== ex.z || err !== ex.e) begin
        n_bad++;
        $display("FAIL hold_cycle%0d: got vld%b rdy%b %h z%b e%b want vld1 rdy0 %h z%b e%b",
                 i, out_valid, in_ready, result, zero, err, ex.res, ex.z, ex.e);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL hold_release: got rdy%b vld%b want rdy1 vld0", in_ready, out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL hold_no_accept: got vld%b want vld0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; op = 3'b100; a = 16'h0001; b = 16'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0000) begin
      n_bad++; $display("FAIL reset_mid: got rdy%b vld%b %h want rdy1 vld0 0000", in_ready, out_valid, result);
    end
    rst = 1'b0;
    repeat (12) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_discard: got vld%b want vld0", out_valid);
    end
    run_op("not_after_rst", 3'b011, 16'h00FF, 16'h0000);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_op("b2b", 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom_range(0, 5)));
  endtask

  initial begin
    test_reset();
    test_logic();
    test_shift();
    test_illegal();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
